// File: rtl/pattern_tx_pkg.sv
// Shared types and default sizes for the pattern_tx serial pattern transmitter.
package pattern_tx_pkg;

  localparam int PW_DEF = 4;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_tx_bit_serializer.sv
// PW-bit load/shift register that owns the serial bit x and the history seq.
// A cycle with neither send_msb nor shift drives x low.
module bit_serializer #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          send_msb,
  input  logic          shift,
  input  logic          seq_en,
  input  logic [PW-1:0] pattern,
  output logic          x,
  output logic [PW-1:0] seq
);

  logic [PW-1:0] pat_q;
  logic [PW-1:0] sh_q;
  logic [PW-1:0] src;
  logic [PW-1:0] sh_n;
  logic          x_n;

  // The first bit of a transfer comes straight from the pattern port so the
  // accepting edge already drives the MSB.
  always_comb begin
    src  = load ? pattern : pat_q;
    x_n  = 1'b0;
    sh_n = sh_q;
    if (send_msb) begin
      x_n  = src[PW-1];
      sh_n = {src[PW-2:0], 1'b0};
    end else if (shift) begin
      x_n  = sh_q[PW-1];
      sh_n = {sh_q[PW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      sh_q  <= '0;
      x     <= 1'b0;
      seq   <= '0;
    end else begin
      if (load) pat_q <= pattern;
      sh_q <= sh_n;
      x    <= x_n;
      if (seq_en) seq <= {seq[PW-2:0], x_n};
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a latched PW-bit pattern count times,
// MSB first, with gap idle bits between repetitions, then pulses done.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [CW-1:0] count,
  input  logic [1:0]    gap,
  output logic          x,
  output logic [PW-1:0] seq,
  output logic          frame,
  output logic          busy,
  output logic          done,
  output state_t        state_dbg
);

  localparam int BW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PW - 1);

  state_t        state, state_n;
  logic [BW-1:0] bit_q, bit_n;
  logic [CW-1:0] reps_q, reps_n;
  logic [1:0]    gap_q, gap_n;
  logic [1:0]    gcnt_q, gcnt_n;
  logic          load, send_msb, shift, seq_en;

  always_comb begin
    state_n  = state;
    bit_n    = bit_q;
    reps_n   = reps_q;
    gap_n    = gap_q;
    gcnt_n   = gcnt_q;
    load     = 1'b0;
    send_msb = 1'b0;
    shift    = 1'b0;
    seq_en   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          seq_en = 1'b1;
          reps_n = count;
          gap_n  = gap;
          bit_n  = '0;
          if (count != '0) begin
            state_n  = SEND;
            send_msb = 1'b1;
          end else begin
            state_n = DONE;
          end
        end
      end
      SEND: begin
        if (bit_q != LAST_BIT) begin
          shift = 1'b1;
          bit_n = bit_q + 1'b1;
        end else begin
          // LSB is on the line: this repetition completes on this edge.
          bit_n = '0;
          if (reps_q != '0) reps_n = reps_q - 1'b1;
          if (reps_q <= CW'(1)) begin
            state_n = DONE;
          end else if (gap_q == 2'd0) begin
            send_msb = 1'b1;
          end else begin
            state_n = GAP;
            gcnt_n  = gap_q;
          end
        end
      end
      GAP: begin
        if (gcnt_q <= 2'd1) begin
          state_n  = SEND;
          send_msb = 1'b1;
          gcnt_n   = '0;
        end else begin
          gcnt_n = gcnt_q - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bit_q  <= '0;
      reps_q <= '0;
      gap_q  <= '0;
      gcnt_q <= '0;
      frame  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      bit_q  <= bit_n;
      reps_q <= reps_n;
      gap_q  <= gap_n;
      gcnt_q <= gcnt_n;
      frame  <= (state_n == SEND);
      busy   <= (state_n == SEND) || (state_n == GAP);
      done   <= (state_n == DONE);
    end
  end

  assign state_dbg = state;

  bit_serializer #(.PW(PW)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .send_msb (send_msb),
    .shift    (shift),
    .seq_en   (seq_en),
    .pattern  (pattern),
    .x        (x),
    .seq      (seq)
  );

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: per-cycle expected {x,frame,busy,done}
// vectors are queued from a behavioural model and popped against the DUT.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  localparam int PW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] pattern;
  logic [CW-1:0] count;
  logic [1:0]    gap;
  logic          x;
  logic [PW-1:0] seq;
  logic          frame;
  logic          busy;
  logic          done;
  state_t        state_dbg;

  int errors = 0;
  int checks = 0;

  // Entry: {check_seq, x, frame, busy, done}
  logic [4:0] exp_q[$];

  pattern_tx #(.PW(PW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .count     (count),
    .gap       (gap),
    .x         (x),
    .seq       (seq),
    .frame     (frame),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic build_expect(input logic [PW-1:0] pat, input int cnt, input int gp);
    for (int r = 0; r < cnt; r++) begin
      for (int b = PW - 1; b >= 0; b--)
        exp_q.push_back({(b == 0), pat[b], 1'b1, 1'b1, 1'b0});
      if (r < cnt - 1)
        for (int g = 0; g < gp; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00000);
  endtask

  // Starts one transfer and checks every cycle until one idle cycle after done.
  // inj > 0 re-pulses start with a different request on that cycle.
  task automatic run_stream(input string name, input logic [PW-1:0] pat,
                            input int cnt, input int gp, input int inj);
    int cyc;
    int busy_n;
    int done_n;
    int exp_busy;
    logic [4:0] e;
    cyc    = 0;
    busy_n = 0;
    done_n = 0;
    exp_busy = (cnt > 0) ? cnt * PW + (cnt - 1) * gp : 0;
    exp_q.delete();
    build_expect(pat, cnt, gp);
    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    count   = cnt[CW-1:0];
    gap     = gp[1:0];
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inj) begin
        start   = 1'b1;
        pattern = ~pat;
        count   = 4'd3;
        gap     = 2'd1;
      end
      e = exp_q.pop_front();
      checks++;
      if ({x, frame, busy, done} !== e[3:0]) begin
        errors++;
        $display("FAIL %s cycle %0d: {x,frame,busy,done} got %b want %b", name, cyc,
                 {x, frame, busy, done}, e[3:0]);
      end
      if (e[4]) begin
        checks++;
        if (seq !== pat) begin
          errors++;
          $display("FAIL %s seq cycle %0d: got %b want %b", name, cyc, seq, pat);
        end
      end
      busy_n += int'(busy === 1'b1);
      done_n += int'(done === 1'b1);
    end
    start = 1'b0;
    checks++;
    if (busy_n != exp_busy) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", name, busy_n, exp_busy);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_n);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    pattern = 4'b1111;
    count   = 4'd2;
    gap     = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x, seq, frame, busy, done} !== 8'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got x=%b seq=%b frame=%b busy=%b done=%b st=%0d want all 0 IDLE",
               x, seq, frame, busy, done, state_dbg);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({x, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got x=%b busy=%b done=%b want 000", x, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start   = 1'b1;
    pattern = 4'b1011;
    count   = 4'd2;
    gap     = 2'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({x, busy, frame} !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_bit3: {x,busy,frame} got %b want 111", {x, busy, frame});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({x, busy, frame, done, seq} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: x=%b busy=%b frame=%b done=%b seq=%b want all 0",
               x, busy, frame, done, seq);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({x, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_quiet %0d: {x,busy,done} got %b want 000", i, {x, busy, done});
      end
    end
    run_stream("after_reset", 4'b1011, 2, 1, 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    count   = '0;
    gap     = '0;
    test_reset();
    run_stream("single_1011", 4'b1011, 1, 0, 0);
    run_stream("gap2_1011", 4'b1011, 2, 2, 0);
    run_stream("b2b_0110", 4'b0110, 3, 0, 0);
    run_stream("count_zero", 4'b1111, 0, 2, 0);
    run_stream("start_mid", 4'b1101, 2, 1, 2);
    run_stream("start_in_done", 4'b1001, 1, 0, 5);
    run_stream("random", 4'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 3)), 0);
    run_stream("count_max", 4'b1010, 15, 3, 0);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have parameter PW, default 4, which sets the pattern width in bits.
REQ-002 SHALL have parameter CW, default 4, which sets the repeat-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port pattern, input, PW bits: the bit pattern to send, MSB first.
REQ-007 SHALL have port count, input, CW bits: the number of pattern repetitions; 0 is legal.
REQ-008 SHALL have port gap, input, 2 bits: the number of idle 0-bits inserted between repetitions.
REQ-009 SHALL have port x, output, 1 bit: the registered serial bit stream.
REQ-010 SHALL have port seq, output, PW bits: the last PW bits driven on x, with the newest bit in seq[0].
REQ-011 SHALL have port frame, output, 1 bit: high while x carries a pattern bit; low during gap bits.
REQ-012 SHALL have port busy, output, 1 bit: high from the accepting edge until the last pattern bit completes.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse after the final bit.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, GAP and DONE; every output SHALL be registered.
REQ-015 In IDLE with start=1, the block SHALL latch pattern, count and gap on that edge; start at any other time SHALL be ignored and latched values SHALL NOT change.
REQ-016 The accepting edge with count>0 SHALL go to SEND and drive x=pattern[PW-1], frame=1 and busy=1; there SHALL be zero added latency.
REQ-017 Each SEND edge SHALL advance one bit, MSB to LSB, so each repetition takes exactly PW cycles.
REQ-018 After the LSB: with remaining reps=0 the block SHALL go to DONE; with gap=0 it SHALL restart at the MSB with no bubble; otherwise it SHALL go to GAP.
REQ-019 GAP SHALL last exactly gap cycles with x=0, frame=0 and busy=1, then SHALL return to SEND at the MSB.
REQ-020 DONE SHALL last 1 cycle with done=1, busy=0, x=0 and frame=0, then SHALL go to IDLE; start in DONE SHALL be ignored.
REQ-021 The accepting edge with count=0 SHALL go directly to DONE; busy SHALL never rise and x SHALL stay 0.
REQ-022 busy SHALL be high for exactly count*PW + (count-1)*gap cycles when count>0.
REQ-023 On every edge, seq SHALL become {seq[PW-2:0], next x}, so seq[0]==x always; seq SHALL hold its value in IDLE.
REQ-024 The remaining-rep counter SHALL be CW bits wide and SHALL decrement once per completed repetition; it SHALL never wrap below 0.
REQ-025 A count of all-ones SHALL send 2^CW-1 repetitions.

Reset
REQ-026 While reset=1 on an edge, the block SHALL take state IDLE, x=0, seq=0, frame=0, busy=0 and done=0, and SHALL clear all counters.
REQ-027 Reset SHALL take priority over start; a reset mid-SEND or mid-GAP SHALL abort the transfer with no done pulse.

Structure
REQ-028 Package pattern_tx_pkg SHALL hold the state enum (IDLE, SEND, GAP, DONE) and the default PW/CW constants.
REQ-029 The design SHALL contain one sub-module, bit_serializer: a PW-bit load/shift register that drives x and seq, controlled by load and shift enables from the FSM.

Verification
REQ-030 The bench SHALL check: pattern=1011, count=1, gap=0 -> x=1,0,1,1 on the 4 cycles after accept; busy high for 4 cycles; done on cycle 5; seq=1011 at that point.
REQ-031 The bench SHALL check: pattern=1011, count=2, gap=2 -> x=1,0,1,1,0,0,1,0,1,1; frame=1111001111; busy high for 10 cycles; then a single done pulse.
REQ-032 The bench SHALL check: pattern=0110, count=3, gap=0 -> x=011001100110 back-to-back with no bubble; busy high for 12 cycles.
REQ-033 The bench SHALL check: count=0 with start -> done=1 on the next cycle; busy=0 and x=0 throughout.
REQ-034 The bench SHALL check: start pulsed again mid-transfer with a different pattern -> it is ignored and the original stream completes unchanged.
REQ-035 The bench SHALL check: reset asserted at the 3rd bit of repetition 1 of 2 -> on the next edge x=0, busy=0 and seq=0, with no done pulse; a fresh start afterwards transmits correctly.
